wired_alu_issue: RTL and testbench
==================================

Name: wired_alu_issue

Overview:
- Single-ALU issue queue that produces the operand/opcode interface consumed by the integer ALU and takes back its combinational result.
- Buffers renamed ALU micro-ops and captures pending source operands from the wakeup bus.
- Selects the oldest ready entry, drives it into the ALU from a dispatch register, and presents the registered result on a valid/ready writeback port.
- Sits between rename/dispatch and the common writeback bus.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush_i  in  1  pipeline flush; drops all in-flight state
- enq_valid_i  in  1  micro-op offered
- enq_ready_o  out  1  queue can accept
- enq_grand_op_i  in  3  ALU group select
- enq_op_i  in  3  ALU sub-op
- enq_selimm_i  in  12  immediate field (msbw/lsbw/sa2)
- enq_pc_i  in  32  instruction PC
- enq_rob_i  in  ROB_W  ROB index
- enq_r0_rdy_i, enq_r1_rdy_i  in  1 each  source already available
- enq_r0_i, enq_r1_i  in  32 each  source data when ready
- enq_r0_tag_i, enq_r1_tag_i  in  TAG_W each  source tag when not ready
- wk_valid_i  in  1  wakeup broadcast valid
- wk_tag_i  in  TAG_W  produced tag
- wk_data_i  in  32  produced data
- alu_r0_o, alu_r1_o, alu_pc_o  out  32 each  ALU operands
- alu_selimm_o  out  12; alu_grand_op_o  out  3; alu_op_o  out  3
- alu_res_i  in  32  ALU result (combinational from the outputs above)
- wb_valid_o  out  1; wb_ready_i  in  1
- wb_rob_o  out  ROB_W; wb_data_o  out  32

Behaviour:
- Reset (async, rst=1):
  - All entry valids, D-stage valid and WB valid clear.
  - All data and alu_* outputs return 0.
  - enq_ready_o=1 after reset.
- Queue:
  - Compacting queue; index 0 is the oldest entry.
  - Enqueue writes the first free slot after compaction.
  - enq_ready_o = (valid count < DEPTH), registered-state based. It does not account for the same-cycle issue.
  - Enqueue happens on enq_valid_i & enq_ready_o & ~flush_i.
- Wakeup:
  - Each cycle wk_valid_i, every valid entry operand with rdy=0 whose tag matches wk_tag_i latches wk_data_i and sets rdy.
  - The same rule applies to an operand being enqueued in the same cycle.
  - An entry becomes selectable the cycle after its last operand wakes.
- Select:
  - The entry is the lowest-index valid entry with both operands rdy.
  - It issues when the D stage is empty or advancing this cycle.
  - The issued entry is removed and higher entries shift down one slot in the same edge.
  - Enqueue and issue in the same cycle are both honoured.
- D stage:
  - Register holding r0, r1, pc, selimm, grand_op, op and rob.
  - alu_* outputs are driven directly from this register.
  - D advances into WB when WB is empty or wb_ready_i=1.
  - On advance, WB captures alu_res_i and rob.
- WB stage:
  - wb_valid_o stays high with stable wb_rob_o and wb_data_o until wb_ready_i.
  - Full throughput is 1 op/cycle.
  - Minimum latency from enqueue with ready operands is 3 edges: enqueue, then select into D, then WB.
- Backpressure: with wb_ready_i=0 and WB full, D holds and select stalls; the queue keeps accepting until full.
- Flush:
  - Clears all entries, D valid and WB valid on the next edge.
  - Enqueue and wakeup in the flush cycle are ignored.
  - wb_valid_o may be high in the flush cycle; a handshake in that cycle is not a commit guarantee, and ROB discards it.
- Result is not self-forwarded; dependents wake only through the external wakeup bus.

Test Plan:
- Ready op: enq ADD with r1=5, r0=7, both rdy, wb_ready_i=1. Expect wb_valid_o=1 with wb_data_o=12 and the correct ROB index exactly 2 cycles after the enqueue edge.
- Wakeup: enq SUB with r1=10 rdy and r0 tag=3 not ready. Two cycles later pulse wk tag=3 data=4. Expect no issue before the wakeup, then wb_data_o=6 two cycles after the ready cycle.
- Age order: enqueue A (r0 tag 1) then B (both rdy), then wake tag 1. Expect B to write back before A; each result appears exactly once.
- Full/backpressure: DEPTH=4, wb_ready_i=0, enqueue 6 ready ops.
  - Expect 1 op in WB, 1 in D, 4 in the queue, and enq_ready_o=0.
  - Then raise wb_ready_i. Expect 6 results in enqueue order on consecutive cycles.
- Same-cycle wakeup on enqueue: enq with r0 tag 9 while wk_valid_i tag=9 data=0x1234. Expect the op to issue with alu_r0_o=0x1234.
- Flush and reset:
  - Fill the queue, assert flush_i for 1 cycle together with an enqueue. Expect empty state next cycle, enq_ready_o=1, and no wb_valid_o afterwards.
  - Assert rst mid-stream. Expect all outputs to go to 0 immediately (asynchronously).

Source files
------------

// File: rtl/wired_alu_issue.sv
// Single-ALU issue queue: age-ordered compacting buffer with operand wakeup,
// a dispatch (D) register driving the external ALU, and a writeback register.
module wired_alu_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int ROB_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [2:0]       enq_grand_op_i,
  input  logic [2:0]       enq_op_i,
  input  logic [11:0]      enq_selimm_i,
  input  logic [31:0]      enq_pc_i,
  input  logic [ROB_W-1:0] enq_rob_i,
  input  logic             enq_r0_rdy_i,
  input  logic             enq_r1_rdy_i,
  input  logic [31:0]      enq_r0_i,
  input  logic [31:0]      enq_r1_i,
  input  logic [TAG_W-1:0] enq_r0_tag_i,
  input  logic [TAG_W-1:0] enq_r1_tag_i,
  input  logic             wk_valid_i,
  input  logic [TAG_W-1:0] wk_tag_i,
  input  logic [31:0]      wk_data_i,
  output logic [31:0]      alu_r0_o,
  output logic [31:0]      alu_r1_o,
  output logic [31:0]      alu_pc_o,
  output logic [11:0]      alu_selimm_o,
  output logic [2:0]       alu_grand_op_o,
  output logic [2:0]       alu_op_o,
  input  logic [31:0]      alu_res_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [ROB_W-1:0] wb_rob_o,
  output logic [31:0]      wb_data_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      r0;
    logic [31:0]      r1;
    logic [31:0]      pc;
    logic [11:0]      selimm;
    logic [2:0]       grand_op;
    logic [2:0]       op;
    logic [ROB_W-1:0] rob;
  } payload_t;

  typedef struct packed {
    logic             valid;
    logic             r0_rdy;
    logic             r1_rdy;
    logic [TAG_W-1:0] r0_tag;
    logic [TAG_W-1:0] r1_tag;
    payload_t         pl;
  } entry_t;

  // Capture a broadcast result into any still-pending operand of a live entry.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_W-1:0] tag,
                                  input logic [31:0] data);
    entry_t r;
    r = e;
    if (v && e.valid && !e.r0_rdy && (e.r0_tag == tag)) begin
      r.r0_rdy = 1'b1;
      r.pl.r0  = data;
    end
    if (v && e.valid && !e.r1_rdy && (e.r1_tag == tag)) begin
      r.r1_rdy = 1'b1;
      r.pl.r1  = data;
    end
    return r;
  endfunction

  entry_t           ent_q  [DEPTH];
  entry_t           ent_d  [DEPTH];
  entry_t           ent_wk [DEPTH+1];
  entry_t           enq_raw;
  entry_t           enq_ent;
  payload_t         sel_pl;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_found;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] enq_slot;
  logic             issue;
  logic             enq_fire;
  logic             d_free;
  logic             d_to_wb;

  payload_t         d_q, d_d;
  logic             d_valid_q, d_valid_d;
  logic             wb_valid_q, wb_valid_d;
  logic [ROB_W-1:0] wb_rob_q, wb_rob_d;
  logic [31:0]      wb_data_q, wb_data_d;

  // Slot DEPTH is a permanent empty entry shifted in at the top on issue.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wake
      assign ent_wk[gi] = wake(ent_q[gi], wk_valid_i, wk_tag_i, wk_data_i);
    end
  endgenerate
  assign ent_wk[DEPTH] = '0;

  always_comb begin
    enq_raw             = '0;
    enq_raw.valid       = 1'b1;
    enq_raw.r0_rdy      = enq_r0_rdy_i;
    enq_raw.r1_rdy      = enq_r1_rdy_i;
    enq_raw.r0_tag      = enq_r0_tag_i;
    enq_raw.r1_tag      = enq_r1_tag_i;
    enq_raw.pl.r0       = enq_r0_rdy_i ? enq_r0_i : 32'd0;
    enq_raw.pl.r1       = enq_r1_rdy_i ? enq_r1_i : 32'd0;
    enq_raw.pl.pc       = enq_pc_i;
    enq_raw.pl.selimm   = enq_selimm_i;
    enq_raw.pl.grand_op = enq_grand_op_i;
    enq_raw.pl.op       = enq_op_i;
    enq_raw.pl.rob      = enq_rob_i;
  end
  assign enq_ent = wake(enq_raw, wk_valid_i, wk_tag_i, wk_data_i);

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(ent_q[i].valid);
    end
  end

  // Scan from the top so the lowest-index (oldest) ready entry wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_pl    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].r0_rdy && ent_q[i].r1_rdy) begin
        sel_found = 1'b1;
        sel_idx   = SEL_W'(i);
        sel_pl    = ent_q[i].pl;
      end
    end
  end

  assign enq_ready_o = (count < CNT_W'(DEPTH));
  assign d_to_wb     = d_valid_q & (~wb_valid_q | wb_ready_i);
  assign d_free      = ~d_valid_q | d_to_wb;
  assign issue       = sel_found & d_free & ~flush_i;
  assign enq_fire    = enq_valid_i & enq_ready_o & ~flush_i;
  assign enq_slot    = count - CNT_W'(issue);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (SEL_W'(i) >= sel_idx)) begin
        ent_d[i] = ent_wk[i+1];
      end else begin
        ent_d[i] = ent_wk[i];
      end
      if (enq_fire && (enq_slot == CNT_W'(i))) begin
        ent_d[i] = enq_ent;
      end
      if (flush_i) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    d_valid_d  = d_valid_q;
    d_d        = d_q;
    wb_valid_d = wb_valid_q;
    wb_rob_d   = wb_rob_q;
    wb_data_d  = wb_data_q;
    if (d_to_wb) begin
      wb_valid_d = 1'b1;
      wb_rob_d   = d_q.rob;
      wb_data_d  = alu_res_i;
      d_valid_d  = 1'b0;
    end else if (wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
    if (issue) begin
      d_valid_d = 1'b1;
      d_d       = sel_pl;
    end
    if (flush_i) begin
      d_valid_d  = 1'b0;
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      d_valid_q  <= 1'b0;
      d_q        <= '0;
      wb_valid_q <= 1'b0;
      wb_rob_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      d_valid_q  <= d_valid_d;
      d_q        <= d_d;
      wb_valid_q <= wb_valid_d;
      wb_rob_q   <= wb_rob_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_r0_o       = d_q.r0;
  assign alu_r1_o       = d_q.r1;
  assign alu_pc_o       = d_q.pc;
  assign alu_selimm_o   = d_q.selimm;
  assign alu_grand_op_o = d_q.grand_op;
  assign alu_op_o       = d_q.op;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rob_o       = wb_rob_q;
  assign wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_wired_alu_issue.sv
// Bench for wired_alu_issue: directed timing checks plus a randomized run
// scored against a per-ROB-index operand model.
module tb_wired_alu_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
  localparam int ROB_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush_i = 1'b0;
  logic             enq_valid_i = 1'b0;
  logic             enq_ready_o;
  logic [2:0]       enq_grand_op_i = '0;
  logic [2:0]       enq_op_i = '0;
  logic [11:0]      enq_selimm_i = '0;
  logic [31:0]      enq_pc_i = '0;
  logic [ROB_W-1:0] enq_rob_i = '0;
  logic             enq_r0_rdy_i = 1'b0;
  logic             enq_r1_rdy_i = 1'b0;
  logic [31:0]      enq_r0_i = '0;
  logic [31:0]      enq_r1_i = '0;
  logic [TAG_W-1:0] enq_r0_tag_i = '0;
  logic [TAG_W-1:0] enq_r1_tag_i = '0;
  logic             wk_valid_i = 1'b0;
  logic [TAG_W-1:0] wk_tag_i = '0;
  logic [31:0]      wk_data_i = '0;
  logic [31:0]      alu_r0_o, alu_r1_o, alu_pc_o;
  logic [11:0]      alu_selimm_o;
  logic [2:0]       alu_grand_op_o, alu_op_o;
  logic [31:0]      alu_res_i;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b1;
  logic [ROB_W-1:0] wb_rob_o;
  logic [31:0]      wb_data_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the integer ALU that sits outside the block.
  function automatic logic [31:0] alu_f(input logic [2:0] gop, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] pc, input logic [11:0] imm);
    if (gop == 3'd0) begin
      case (op)
        3'd0:    return a + b;
        3'd1:    return b - a;
        3'd2:    return a & b;
        3'd3:    return a | b;
        3'd4:    return a ^ b;
        default: return a << b[4:0];
      endcase
    end
    return a ^ b ^ pc ^ {20'd0, imm};
  endfunction

  assign alu_res_i = alu_f(alu_grand_op_o, alu_op_o, alu_r0_o, alu_r1_o, alu_pc_o, alu_selimm_o);

  wired_alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_grand_op_i(enq_grand_op_i), .enq_op_i(enq_op_i),
    .enq_selimm_i(enq_selimm_i), .enq_pc_i(enq_pc_i), .enq_rob_i(enq_rob_i),
    .enq_r0_rdy_i(enq_r0_rdy_i), .enq_r1_rdy_i(enq_r1_rdy_i),
    .enq_r0_i(enq_r0_i), .enq_r1_i(enq_r1_i),
    .enq_r0_tag_i(enq_r0_tag_i), .enq_r1_tag_i(enq_r1_tag_i),
    .wk_valid_i(wk_valid_i), .wk_tag_i(wk_tag_i), .wk_data_i(wk_data_i),
    .alu_r0_o(alu_r0_o), .alu_r1_o(alu_r1_o), .alu_pc_o(alu_pc_o),
    .alu_selimm_o(alu_selimm_o), .alu_grand_op_o(alu_grand_op_o), .alu_op_o(alu_op_o),
    .alu_res_i(alu_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rob_o(wb_rob_o), .wb_data_o(wb_data_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid_i = 1'b0;
    wk_valid_i  = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic drive_enq(input logic [2:0] gop, input logic [2:0] op,
                           input logic [31:0] pc, input logic [11:0] imm,
                           input logic [ROB_W-1:0] rob,
                           input logic r0r, input logic [31:0] r0, input logic [TAG_W-1:0] r0t,
                           input logic r1r, input logic [31:0] r1, input logic [TAG_W-1:0] r1t);
    enq_valid_i = 1'b1;
    enq_grand_op_i = gop;  enq_op_i = op;
    enq_pc_i = pc;         enq_selimm_i = imm;  enq_rob_i = rob;
    enq_r0_rdy_i = r0r;    enq_r0_i = r0;       enq_r0_tag_i = r0t;
    enq_r1_rdy_i = r1r;    enq_r1_i = r1;       enq_r1_tag_i = r1t;
  endtask

  // Reference model: one record per in-flight ROB index.
  logic        m_live [32];
  logic        m_r0k [32];
  logic        m_r1k [32];
  logic [31:0] m_r0 [32];
  logic [31:0] m_r1 [32];
  logic [TAG_W-1:0] m_r0t [32];
  logic [TAG_W-1:0] m_r1t [32];
  logic [31:0] m_pc [32];
  logic [11:0] m_imm [32];
  logic [2:0]  m_gop [32];
  logic [2:0]  m_op [32];
  int n_enq = 0;
  int n_done = 0;

  task automatic model_step();
    int r;
    logic [31:0] exp;
    if (wb_valid_o && wb_ready_i) begin
      r = int'(wb_rob_o);
      chk("rnd_wb_live", {31'd0, m_live[r]}, 32'd1);
      chk("rnd_wb_srcs_known", {30'd0, m_r0k[r], m_r1k[r]}, 32'd3);
      exp = alu_f(m_gop[r], m_op[r], m_r0[r], m_r1[r], m_pc[r], m_imm[r]);
      chk("rnd_wb_data", wb_data_o, exp);
      $display("wb rob=%0d data=0x%08h", r, wb_data_o);
      m_live[r] = 1'b0;
      n_done++;
    end
    if (wk_valid_i) begin
      for (int k = 0; k < 32; k++) begin
        if (m_live[k] && !m_r0k[k] && m_r0t[k] == wk_tag_i) begin m_r0k[k] = 1'b1; m_r0[k] = wk_data_i; end
        if (m_live[k] && !m_r1k[k] && m_r1t[k] == wk_tag_i) begin m_r1k[k] = 1'b1; m_r1[k] = wk_data_i; end
      end
    end
    if (enq_valid_i && enq_ready_o) begin
      r = int'(enq_rob_i);
      m_live[r] = 1'b1;
      m_r0k[r] = enq_r0_rdy_i; m_r0[r] = enq_r0_i; m_r0t[r] = enq_r0_tag_i;
      m_r1k[r] = enq_r1_rdy_i; m_r1[r] = enq_r1_i; m_r1t[r] = enq_r1_tag_i;
      if (wk_valid_i && !m_r0k[r] && m_r0t[r] == wk_tag_i) begin m_r0k[r] = 1'b1; m_r0[r] = wk_data_i; end
      if (wk_valid_i && !m_r1k[r] && m_r1t[r] == wk_tag_i) begin m_r1k[r] = 1'b1; m_r1[r] = wk_data_i; end
      m_pc[r] = enq_pc_i; m_imm[r] = enq_selimm_i;
      m_gop[r] = enq_grand_op_i; m_op[r] = enq_op_i;
      n_enq++;
    end
  endtask

  initial begin
    logic [ROB_W-1:0] robq[$];
    logic [31:0]      datq[$];
    logic [ROB_W-1:0] rob_ctr;
    int cnt;
    int live_cnt;

    for (int k = 0; k < 32; k++) m_live[k] = 1'b0;

    // Reset state
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enq_ready", {31'd0, enq_ready_o}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_alu_r0", alu_r0_o, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    rst = 1'b0;
    tick();

    // Ready op: ADD 7+5, result exactly two edges after the enqueue edge
    wb_ready_i = 1'b1;
    drive_enq(3'd0, 3'd0, 32'h100, 12'd0, 5'd1, 1'b1, 32'd7, '0, 1'b1, 32'd5, '0);
    tick();
    idle();
    chk("ready_wb_early0", {31'd0, wb_valid_o}, 32'd0);
    tick();
    chk("ready_wb_early1", {31'd0, wb_valid_o}, 32'd0);
    chk("ready_alu_r0", alu_r0_o, 32'd7);
    chk("ready_alu_r1", alu_r1_o, 32'd5);
    tick();
    chk("ready_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("ready_wb_data", wb_data_o, 32'd12);
    chk("ready_wb_rob", {27'd0, wb_rob_o}, 32'd1);
    tick();
    chk("ready_wb_once", {31'd0, wb_valid_o}, 32'd0);

    // Wakeup: SUB r1=10, r0 waits on tag 3
    drive_enq(3'd0, 3'd1, 32'h200, 12'd0, 5'd2, 1'b0, 32'd0, 6'd3, 1'b1, 32'd10, '0);
    tick();
    idle();
    tick();
    chk("wk_no_early_issue", {31'd0, wb_valid_o}, 32'd0);
    wk_valid_i = 1'b1; wk_tag_i = 6'd3; wk_data_i = 32'd4;
    tick();
    idle();
    chk("wk_wb_not_yet", {31'd0, wb_valid_o}, 32'd0);
    tick();
    chk("wk_alu_r0", alu_r0_o, 32'd4);
    chk("wk_alu_r1", alu_r1_o, 32'd10);
    tick();
    chk("wk_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("wk_wb_data", wb_data_o, 32'd6);
    chk("wk_wb_rob", {27'd0, wb_rob_o}, 32'd2);
    tick();

    // Age order: A waits on tag 1, B ready; B must write back first
    drive_enq(3'd0, 3'd0, 32'h0, 12'd0, 5'd3, 1'b0, 32'd0, 6'd1, 1'b1, 32'd100, '0);
    tick();
    drive_enq(3'd0, 3'd0, 32'h0, 12'd0, 5'd4, 1'b1, 32'd1, '0, 1'b1, 32'd2, '0);
    tick();
    idle();
    wk_valid_i = 1'b1; wk_tag_i = 6'd1; wk_data_i = 32'd50;
    for (int c = 0; c < 7; c++) begin
      if (wb_valid_o && wb_ready_i) begin
        robq.push_back(wb_rob_o);
        datq.push_back(wb_data_o);
      end
      tick();
      wk_valid_i = 1'b0;
    end
    chk("age_wb_count", robq.size(), 32'd2);
    chk("age_first_rob", robq.size() > 0 ? {27'd0, robq[0]} : 32'hFFFF_FFFF, 32'd4);
    chk("age_first_data", datq.size() > 0 ? datq[0] : 32'hFFFF_FFFF, 32'd3);
    chk("age_second_rob", robq.size() > 1 ? {27'd0, robq[1]} : 32'hFFFF_FFFF, 32'd3);
    chk("age_second_data", datq.size() > 1 ? datq[1] : 32'hFFFF_FFFF, 32'd150);

    // Full / backpressure: six ready ops with the writeback port stalled
    wb_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_enq_ready_%0d", k), {31'd0, enq_ready_o}, 32'd1);
      drive_enq(3'd0, 3'd0, 32'h0, 12'd0, ROB_W'(10 + k), 1'b1, 32'(k + 1), '0, 1'b1, 32'(100 * (k + 1)), '0);
      tick();
    end
    idle();
    chk("bp_full_not_ready", {31'd0, enq_ready_o}, 32'd0);
    chk("bp_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("bp_wb_rob", {27'd0, wb_rob_o}, 32'd10);
    chk("bp_d_holds_second", alu_r0_o, 32'd2);
    tick();
    chk("bp_wb_rob_stable", {27'd0, wb_rob_o}, 32'd10);
    chk("bp_wb_data_stable", wb_data_o, 32'd101);
    wb_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp_drain_valid_%0d", k), {31'd0, wb_valid_o}, 32'd1);
      chk($sformatf("bp_drain_rob_%0d", k), {27'd0, wb_rob_o}, 32'(10 + k));
      chk($sformatf("bp_drain_data_%0d", k), wb_data_o, 32'(101 * (k + 1)));
      tick();
    end
    chk("bp_drained", {31'd0, wb_valid_o}, 32'd0);

    // Same-cycle wakeup on enqueue
    drive_enq(3'd0, 3'd4, 32'h0, 12'd0, 5'd20, 1'b0, 32'd0, 6'd9, 1'b1, 32'd0, '0);
    wk_valid_i = 1'b1; wk_tag_i = 6'd9; wk_data_i = 32'h1234;
    tick();
    idle();
    tick();
    chk("samewk_alu_r0", alu_r0_o, 32'h1234);
    tick();
    chk("samewk_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("samewk_wb_data", wb_data_o, 32'h1234);
    tick();

    // Flush with a full queue and an enqueue in the same cycle
    wb_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_enq(3'd1, 3'd0, 32'h40, 12'd3, ROB_W'(k), 1'b1, 32'(k), '0, 1'b1, 32'd1, '0);
      tick();
    end
    chk("flush_pre_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    drive_enq(3'd0, 3'd0, 32'h0, 12'd0, 5'd6, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0);
    flush_i = 1'b1;
    tick();
    idle();
    chk("flush_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("flush_enq_ready", {31'd0, enq_ready_o}, 32'd1);
    wb_ready_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (wb_valid_o) cnt++;
      tick();
    end
    chk("flush_no_wb_after", cnt, 32'd0);
    drive_enq(3'd0, 3'd0, 32'h0, 12'd0, 5'd7, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0);
    flush_i = 1'b1;
    tick();
    idle();
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_valid_o) cnt++;
      tick();
    end
    chk("flush_enq_dropped", cnt, 32'd0);

    // Asynchronous reset mid-stream
    wb_ready_i = 1'b0;
    drive_enq(3'd1, 3'd2, 32'hABCD, 12'h5A5, 5'd8, 1'b1, 32'h11, '0, 1'b1, 32'h22, '0);
    tick();
    drive_enq(3'd1, 3'd3, 32'h1234, 12'h0F0, 5'd9, 1'b1, 32'h33, '0, 1'b1, 32'h44, '0);
    tick();
    idle();
    tick();
    chk("arst_pre_wb_valid", {31'd0, wb_valid_o}, 32'd1);
    chk("arst_pre_alu_pc", alu_pc_o, 32'h1234);
    #3 rst = 1'b1;
    #1;
    chk("arst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
    chk("arst_wb_data", wb_data_o, 32'd0);
    chk("arst_wb_rob", {27'd0, wb_rob_o}, 32'd0);
    chk("arst_alu_r0", alu_r0_o, 32'd0);
    chk("arst_alu_r1", alu_r1_o, 32'd0);
    chk("arst_alu_pc", alu_pc_o, 32'd0);
    chk("arst_alu_ctl", {17'd0, alu_selimm_o, alu_grand_op_o}, 32'd0);
    chk("arst_alu_op", {29'd0, alu_op_o}, 32'd0);
    chk("arst_enq_ready", {31'd0, enq_ready_o}, 32'd1);
    rst = 1'b0;
    wb_ready_i = 1'b1;
    tick();
    tick();
    chk("arst_stays_empty", {31'd0, wb_valid_o}, 32'd0);

    // Randomized traffic scored against the model
    rob_ctr = '0;
    for (int c = 0; c < 400; c++) begin
      wb_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        drive_enq(3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, 12'($urandom),
                  rob_ctr,
                  ($urandom_range(0, 1) == 1), $urandom, TAG_W'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1), $urandom, TAG_W'($urandom_range(0, 7)));
      end else begin
        enq_valid_i = 1'b0;
      end
      wk_valid_i = ($urandom_range(0, 2) == 0);
      wk_tag_i   = TAG_W'($urandom_range(0, 7));
      wk_data_i  = $urandom;
      if (enq_valid_i && enq_ready_o) begin
        model_step();
        rob_ctr = rob_ctr + 1'b1;
      end else begin
        model_step();
      end
      tick();
    end
    idle();
    wb_ready_i = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wk_valid_i = 1'b1;
      wk_tag_i   = TAG_W'(t);
      wk_data_i  = $urandom;
      model_step();
      tick();
    end
    wk_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      model_step();
      tick();
    end
    live_cnt = 0;
    for (int k = 0; k < 32; k++) if (m_live[k]) live_cnt++;
    chk("rnd_all_drained", live_cnt, 32'd0);
    chk("rnd_done_count", n_done, n_enq);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL tb_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
